// File: rtl/sqrt_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_sched_pkg - shared types and constants for the sqrt scheduler       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int RAD_W    = 32;
    localparam int ROOT_W   = 16;
    localparam int NOM_LAT  = 18;
    localparam int WDOG_DEF = 24;

endpackage
`default_nettype wire

// File: rtl/sqrt_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_sched_if - request, response and engine signals of the scheduler    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sqrt_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import sqrt_sched_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*RAD_W-1:0] req_x;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [ROOT_W-1:0]     rsp_root;
    logic                  rsp_err;
    logic                  rsp_ready;
    logic                  eng_clear;
    logic [RAD_W-1:0]      eng_x;
    logic                  eng_rdy;
    logic [ROOT_W-1:0]     eng_acc;
    logic                  busy;

    // master is the scheduler; slave is the requesters, consumer and engine
    modport master (
        input  req_valid, req_x, rsp_ready, eng_rdy, eng_acc,
        output req_ready, rsp_valid, rsp_id, rsp_root, rsp_err,
               eng_clear, eng_x, busy
    );

    modport slave (
        output req_valid, req_x, rsp_ready, eng_rdy, eng_acc,
        input  req_ready, rsp_valid, rsp_id, rsp_root, rsp_err,
               eng_clear, eng_x, busy
    );

endinterface
`default_nettype wire

// File: rtl/sqrt_sched_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter - combinational round-robin pick starting at the pointer      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic [NREQ-1:0] req_i,
    input  wire logic [IDW-1:0]  ptr_i,
    input  wire logic            en_i,
    output logic      [NREQ-1:0] gnt_o,
    output logic      [IDW-1:0]  idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_i) + i) % NREQ;
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sqrt_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_sched - shares one iterative sqrt engine among NREQ requesters      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sqrt_sched
    import sqrt_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int WDOG = WDOG_DEF
) (
    input  wire logic   clk,
    input  wire logic   reset,
    sqrt_sched_if.master bus
);

    localparam int WDW = $clog2(WDOG);

    state_e              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic [IDW-1:0]      id_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [RAD_W-1:0]    eng_x_q;
    logic [ROOT_W-1:0]   root_q;
    logic                err_q;
    logic                valid_q;
    logic                clear_q;
    logic [WDW-1:0]      wd_q;
    logic [NREQ-1:0]     win_gnt;
    logic [IDW-1:0]      win_idx;
    logic                arb_en;

    // Grant only from IDLE and never while reset is asserted
    assign arb_en = (state_q == IDLE) && reset;
    assign ptr_d  = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            rsp_id_q <= '0;
            eng_x_q  <= '0;
            root_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            clear_q  <= 1'b1;
            wd_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    clear_q <= 1'b0;
                    if (|win_gnt) begin
                        eng_x_q <= bus.req_x[int'(win_idx)*RAD_W +: RAD_W];
                        id_q    <= win_idx;
                        ptr_q   <= ptr_d;
                        clear_q <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    clear_q <= 1'b0;
                    wd_q    <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    wd_q <= wd_q + 1'b1;
                    // The engine keeps iterating after done, so only the first ready counts
                    if (bus.eng_rdy) begin
                        root_q   <= bus.eng_acc;
                        err_q    <= 1'b0;
                        rsp_id_q <= id_q;
                        valid_q  <= 1'b1;
                        state_q  <= RESP;
                    end else if (wd_q == WDW'(WDOG - 1)) begin
                        root_q   <= '0;
                        err_q    <= 1'b1;
                        rsp_id_q <= id_q;
                        valid_q  <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = win_gnt;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_root  = root_q;
    assign bus.rsp_err   = err_q;
    assign bus.eng_clear = clear_q;
    assign bus.eng_x     = eng_x_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire
